// File: rtl/serial_pattern_gen.sv
// Serial bit-stream transmitter: latches pattern/length/reps on start and shifts the
// pattern out MSB-first, repeating the frame reps+1 times. Optional even-parity bit per frame
// is enabled by defining SERIAL_PATTERN_GEN_PARITY_EN.
module serial_pattern_gen #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 5,
    parameter int REP_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [CNT_W-1:0]   length,
    input  logic [REP_W-1:0]   reps,
    output logic               X,
    output logic               valid,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        PAR   = 2'd2,
`endif
        FIN   = 2'd3
    } state_t;

`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    // Even parity over the low n bits of a pattern.
    function automatic logic even_parity(input logic [MAX_LEN-1:0] bits, input logic [CNT_W-1:0] n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            p = p ^ (bits[i] & (CNT_W'(i) < n));
        end
        return p;
    endfunction
`endif

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   reps_q, reps_d;
    logic [REP_W-1:0]   frame_q, frame_d;
    logic               x_q, x_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [CNT_W-1:0]   len_clamp_s;
    logic [MAX_LEN-1:0] start_shift_s;
    logic [MAX_LEN-1:0] top_shift_s;
    logic [MAX_LEN-1:0] next_shift_s;

    // Lengths above MAX_LEN are clamped; shifted copies give the bit to send next.
    assign len_clamp_s   = (length > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : length;
    assign start_shift_s = pattern >> (len_clamp_s - CNT_W'(1));
    assign top_shift_s   = pat_q >> (len_q - CNT_W'(1));
    assign next_shift_s  = pat_q >> (idx_q - CNT_W'(1));

    // State, latched transmission parameters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= {MAX_LEN{1'b0}};
            len_q   <= {CNT_W{1'b0}};
            idx_q   <= {CNT_W{1'b0}};
            reps_q  <= {REP_W{1'b0}};
            frame_q <= {REP_W{1'b0}};
            x_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            reps_q  <= reps_d;
            frame_q <= frame_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; outputs are computed for the next cycle and registered.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        reps_d  = reps_q;
        frame_d = frame_q;
        x_d     = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_clamp_s;
                    reps_d  = reps;
                    frame_d = {REP_W{1'b0}};
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                    par_d   = even_parity(pattern, len_clamp_s);
`endif
                    if (len_clamp_s == {CNT_W{1'b0}}) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = SHIFT;
                        idx_d   = len_clamp_s - CNT_W'(1);
                        x_d     = start_shift_s[0];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                if (idx_q != {CNT_W{1'b0}}) begin
                    idx_d = idx_q - CNT_W'(1);
                    x_d   = next_shift_s[0];
                end else begin
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                    state_d = PAR;
                    x_d     = par_q;
`else
                    if (frame_q < reps_q) begin
                        frame_d = frame_q + REP_W'(1);
                        idx_d   = len_q - CNT_W'(1);
                        x_d     = top_shift_s[0];
                    end else begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
            PAR: begin
                if (frame_q < reps_q) begin
                    state_d = SHIFT;
                    frame_d = frame_q + REP_W'(1);
                    idx_d   = len_q - CNT_W'(1);
                    x_d     = top_shift_s[0];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign X     = x_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: directed scenarios plus randomized frames,
// checked cycle by cycle against a stream model built from the frame rules.
module tb_serial_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] pattern;
    logic [4:0]  length;
    logic [3:0]  reps;
    logic        X;
    logic        valid;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    serial_pattern_gen #(.MAX_LEN(16), .CNT_W(5), .REP_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pattern (pattern),
        .length  (length),
        .reps    (reps),
        .X       (X),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed {X,valid,busy,done}=%b expected %b", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check(tag, {X, valid, busy, done}, 4'b0000);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic transmit(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r,
                            input bit disturb, input string tag);
        int          n;
        logic [31:0] mask;
        logic        pb;
        n    = (l > 5'd16) ? 16 : int'(l);
        mask = (32'd1 << n) - 32'd1;
        pb   = ^({16'd0, p} & mask);
        exp_q.delete();
        if (n > 0) begin
            for (int f = 0; f <= int'(r); f++) begin
                for (int i = n - 1; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0});
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
                exp_q.push_back({pb, 1'b1, 1'b1, 1'b0});
`endif
            end
        end
        exp_q.push_back(4'b0001);
        pattern = p;
        length  = l;
        reps    = r;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        pattern = 16'($urandom);
        length  = 5'($urandom);
        reps    = 4'($urandom);
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s cyc%0d", tag, k + 1), {X, valid, busy, done}, exp_q[k]);
            if (k < exp_q.size() - 1) begin
                if (disturb && k == 1 && exp_q.size() >= 3) begin
                    start   = 1'b1;
                    pattern = 16'hFFFF;
                    length  = 5'($urandom);
                    reps    = 4'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        pattern = 16'd0;
        length  = 5'd0;
        reps    = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", {X, valid, busy, done}, 4'b0000);
        rst = 1'b0;
        check_idle("idle_after_reset");

        transmit(16'h000C, 5'd4, 4'd0, 1'b0, "s1_single");
        check_idle("s1_idle");
        transmit(16'h0005, 5'd3, 4'd2, 1'b0, "s2_repeat");
        check_idle("s2_idle");
        transmit(16'h1234, 5'd0, 4'd3, 1'b0, "s3_len0");
        check_idle("s3_len0_idle");
        transmit(16'h8001, 5'd20, 4'd0, 1'b0, "s3_clamp");
        check_idle("s3_clamp_idle");
        transmit(16'h000C, 5'd4, 4'd0, 1'b1, "s4_ignore");
        transmit(16'h0003, 5'd2, 4'd0, 1'b0, "s4_b2b");
        check_idle("s4_idle");
        transmit(16'h0000, 5'd16, 4'd0, 1'b0, "full_zero");
        transmit(16'hFFFF, 5'd16, 4'd1, 1'b1, "full_ones_b2b");
        check_idle("full_idle");

        // Abort mid-frame with reset, then restart straight away.
        pattern = 16'h000C;
        length  = 5'd4;
        reps    = 4'd0;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("s5_cyc1", {X, valid, busy, done}, 4'b1110);
        @(negedge clk);
        check("s5_cyc2", {X, valid, busy, done}, 4'b1110);
        rst = 1'b1;
        @(negedge clk);
        check("s5_aborted", {X, valid, busy, done}, 4'b0000);
        rst = 1'b0;
        transmit(16'h000C, 5'd4, 4'd0, 1'b0, "s5_restart");
        check_idle("s5_idle");

        for (int t = 0; t < 25; t++) begin
            transmit(16'($urandom), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
            if ($urandom_range(0, 1) == 1) check_idle($sformatf("rand%0d_idle", t));
        end
        check_idle("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
